// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - MODE encoding shared by reg_universal and its next-value logic
//
// Contents:
//   MODE_W     width of the MODE select
//   MODE_*     operation codes HOLD, LOAD, INC, DEC, SHL, SHR, ROL, ROR
package reg_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd6;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd7;

endpackage

// File: rtl/reg_next_value.sv
// rtl/reg_next_value.sv - combinational next OUT / CARRY_OUT for reg_universal
//
// Optional feature: REG_SATURATE_EN (INC/DEC clamp at all-ones / zero instead of wrapping)
//
// Ports:
//   mode        operation select (reg_pkg MODE_* codes)
//   cur_value   current register contents
//   cur_carry   current carry flag (kept on HOLD)
//   load_value  parallel load data
//   ser_in      serial fill bit for SHL / SHR
//   next_value  register contents after this edge
//   next_carry  carry / borrow / shifted-out bit after this edge
module reg_next_value
  import reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  cur_value,
  input  logic              cur_carry,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              ser_in,
  output logic [WIDTH-1:0]  next_value,
  output logic              next_carry
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  // One extra bit so the carry out of INC and the borrow out of DEC
  // land in bit WIDTH of the result.
  logic [WIDTH:0] inc_sum;
  logic [WIDTH:0] dec_diff;

  assign inc_sum  = {1'b0, cur_value} + ONE;
  assign dec_diff = {1'b0, cur_value} - ONE;

  always_comb begin
    next_value = cur_value;
    next_carry = cur_carry;
    case (mode)
      MODE_HOLD: begin
        next_value = cur_value;
        next_carry = cur_carry;
      end
      MODE_LOAD: begin
        next_value = load_value;
        next_carry = 1'b0;
      end
      MODE_INC: begin
        next_carry = inc_sum[WIDTH];
`ifdef REG_SATURATE_EN
        next_value = inc_sum[WIDTH] ? {WIDTH{1'b1}} : inc_sum[WIDTH-1:0];
`else
        next_value = inc_sum[WIDTH-1:0];
`endif
      end
      MODE_DEC: begin
        next_carry = dec_diff[WIDTH];
`ifdef REG_SATURATE_EN
        next_value = dec_diff[WIDTH] ? {WIDTH{1'b0}} : dec_diff[WIDTH-1:0];
`else
        next_value = dec_diff[WIDTH-1:0];
`endif
      end
      MODE_SHL: begin
        next_value = {cur_value[WIDTH-2:0], ser_in};
        next_carry = cur_value[WIDTH-1];
      end
      MODE_SHR: begin
        next_value = {ser_in, cur_value[WIDTH-1:1]};
        next_carry = cur_value[0];
      end
      MODE_ROL: begin
        next_value = {cur_value[WIDTH-2:0], cur_value[WIDTH-1]};
        next_carry = cur_value[WIDTH-1];
      end
      MODE_ROR: begin
        next_value = {cur_value[0], cur_value[WIDTH-1:1]};
        next_carry = cur_value[0];
      end
      default: begin
        next_value = cur_value;
        next_carry = cur_carry;
      end
    endcase
  end

endmodule

// File: rtl/reg_universal.sv
// rtl/reg_universal.sv - WIDTH-bit universal register with carry and zero flags
//
// Optional feature: REG_SATURATE_EN (handled inside reg_next_value)
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   CLEAR      synchronous active-high reset, loads RESET_VALUE, clears carry
//   PRESET     synchronous active-high, loads all-ones, clears carry
//   MODE       operation select (reg_pkg MODE_* codes)
//   IN         parallel load data
//   SER_IN     serial fill bit for SHL / SHR
//   OUT        registered contents
//   CARRY_OUT  registered carry / borrow / shifted-out bit
//   ZERO       combinational, high when OUT == 0
module reg_universal
  import reg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              CLK,
  input  logic              CLEAR,
  input  logic              PRESET,
  input  logic [MODE_W-1:0] MODE,
  input  logic [WIDTH-1:0]  IN,
  input  logic              SER_IN,
  output logic [WIDTH-1:0]  OUT,
  output logic              CARRY_OUT,
  output logic              ZERO
);

  logic [WIDTH-1:0] next_value;
  logic             next_carry;

  reg_next_value #(
    .WIDTH (WIDTH)
  ) u_next (
    .mode       (MODE),
    .cur_value  (OUT),
    .cur_carry  (CARRY_OUT),
    .load_value (IN),
    .ser_in     (SER_IN),
    .next_value (next_value),
    .next_carry (next_carry)
  );

  // CLEAR beats PRESET beats MODE; a pending operation is dropped on CLEAR.
  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      OUT       <= RESET_VALUE;
      CARRY_OUT <= 1'b0;
    end else if (PRESET) begin
      OUT       <= {WIDTH{1'b1}};
      CARRY_OUT <= 1'b0;
    end else begin
      OUT       <= next_value;
      CARRY_OUT <= next_carry;
    end
  end

  assign ZERO = (OUT == {WIDTH{1'b0}});

endmodule
